// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - decode, forwarding and ALU-side signals of the ID/EX operand stage
// master is the pipeline side that drives decode/forwarding inputs; slave is the stage itself.
interface id_ex_operand_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  stall_i;
  logic                  flush_i;
  logic                  valid_i;
  logic [3:0]            alu_op_i;
  logic                  alu_src_i;
  logic                  reg_write_i;
  logic [ADDR_WIDTH-1:0] rs1_addr_i;
  logic [ADDR_WIDTH-1:0] rs2_addr_i;
  logic [ADDR_WIDTH-1:0] rd_addr_i;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic [DATA_WIDTH-1:0] rs2_data_i;
  logic [DATA_WIDTH-1:0] imm_i;
  logic                  ex_mem_reg_write_i;
  logic [ADDR_WIDTH-1:0] ex_mem_rd_i;
  logic [DATA_WIDTH-1:0] ex_mem_result_i;
  logic                  mem_wb_reg_write_i;
  logic [ADDR_WIDTH-1:0] mem_wb_rd_i;
  logic [DATA_WIDTH-1:0] mem_wb_result_i;
  logic [3:0]            alu_operation_o;
  logic [DATA_WIDTH-1:0] alu_a_o;
  logic [DATA_WIDTH-1:0] alu_b_o;
  logic [DATA_WIDTH-1:0] store_data_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic                  reg_write_o;
  logic                  valid_o;

  modport master (
    output stall_i, flush_i, valid_i, alu_op_i, alu_src_i, reg_write_i,
           rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_data_i, rs2_data_i, imm_i,
           ex_mem_reg_write_i, ex_mem_rd_i, ex_mem_result_i,
           mem_wb_reg_write_i, mem_wb_rd_i, mem_wb_result_i,
    input  alu_operation_o, alu_a_o, alu_b_o, store_data_o, rd_addr_o, reg_write_o, valid_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, alu_op_i, alu_src_i, reg_write_i,
           rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_data_i, rs2_data_i, imm_i,
           ex_mem_reg_write_i, ex_mem_rd_i, ex_mem_result_i,
           mem_wb_reg_write_i, mem_wb_rd_i, mem_wb_result_i,
    output alu_operation_o, alu_a_o, alu_b_o, store_data_o, rd_addr_o, reg_write_o, valid_o
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with EX-stage operand forwarding
// Registers decoded fields, then forwards EX/MEM and MEM/WB results onto ALU A/B and store data.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  id_ex_operand_stage_if.slave    bus
);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_SRL = 4'd3;

  logic                  r_valid;
  logic                  r_reg_write;
  logic [3:0]            r_alu_op;
  logic                  r_alu_src;
  logic [ADDR_WIDTH-1:0] r_rs1_addr;
  logic [ADDR_WIDTH-1:0] r_rs2_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rs1_data;
  logic [DATA_WIDTH-1:0] r_rs2_data;
  logic [DATA_WIDTH-1:0] r_imm;

  logic [DATA_WIDTH-1:0] w_rs1_fwd;
  logic [DATA_WIDTH-1:0] w_rs2_fwd;
  logic [DATA_WIDTH-1:0] w_b_pre;
  logic                  w_is_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || (bus.flush_i && !reset)) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu_op    <= OP_ADD;
      r_alu_src   <= 1'b0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd_addr   <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
    end else if (!bus.stall_i) begin
      r_valid     <= bus.valid_i;
      r_reg_write <= bus.reg_write_i & bus.valid_i;
      r_alu_op    <= bus.alu_op_i;
      r_alu_src   <= bus.alu_src_i;
      r_rs1_addr  <= bus.rs1_addr_i;
      r_rs2_addr  <= bus.rs2_addr_i;
      r_rd_addr   <= bus.rd_addr_i;
      r_rs1_data  <= bus.rs1_data_i;
      r_rs2_data  <= bus.rs2_data_i;
      r_imm       <= bus.imm_i;
    end
  end

  // x0 is hardwired zero, so a write to it must never be forwarded; EX/MEM is newer than MEM/WB.
  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [ADDR_WIDTH-1:0] rs,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  em_we,
    input logic [ADDR_WIDTH-1:0] em_rd,
    input logic [DATA_WIDTH-1:0] em_res,
    input logic                  mw_we,
    input logic [ADDR_WIDTH-1:0] mw_rd,
    input logic [DATA_WIDTH-1:0] mw_res
  );
    logic [DATA_WIDTH-1:0] v;
    v = rf_data;
    if (em_we && (em_rd != '0) && (em_rd == rs))
      v = em_res;
    else if (mw_we && (mw_rd != '0) && (mw_rd == rs))
      v = mw_res;
    return v;
  endfunction

  always_comb begin
    w_rs1_fwd = fwd_sel(r_rs1_addr, r_rs1_data,
                        bus.ex_mem_reg_write_i, bus.ex_mem_rd_i, bus.ex_mem_result_i,
                        bus.mem_wb_reg_write_i, bus.mem_wb_rd_i, bus.mem_wb_result_i);
    w_rs2_fwd = fwd_sel(r_rs2_addr, r_rs2_data,
                        bus.ex_mem_reg_write_i, bus.ex_mem_rd_i, bus.ex_mem_result_i,
                        bus.mem_wb_reg_write_i, bus.mem_wb_rd_i, bus.mem_wb_result_i);
  end

  assign w_b_pre    = r_alu_src ? r_imm : w_rs2_fwd;
  assign w_is_shift = (r_alu_op == OP_SLL) || (r_alu_op == OP_SRL);

  assign bus.alu_operation_o = r_alu_op;
  assign bus.alu_a_o         = w_rs1_fwd;
  assign bus.alu_b_o         = w_is_shift ? {{(DATA_WIDTH-SHAMT_WIDTH){1'b0}}, w_b_pre[SHAMT_WIDTH-1:0]}
                                          : w_b_pre;
  assign bus.store_data_o    = w_rs2_fwd;
  assign bus.rd_addr_o       = r_rd_addr;
  assign bus.reg_write_o     = r_reg_write & r_valid;
  assign bus.valid_o         = r_valid;
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding for the 32-bit RISC-V core.
- Captures decoded operands and control from decode. Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Drives the ALU's ALU_Operation_i, A_i and B_i directly, and drives store data to the memory stage.

Parameters:
- DATA_WIDTH, 32, width of operands and results.
- ADDR_WIDTH, 5, register-index width.
- SHAMT_WIDTH, 5, number of low B bits kept for shift operations.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall_i  input  1  hold the current stage contents.
- flush_i  input  1  replace the captured contents with a bubble.
- valid_i  input  1  the decode-stage instruction is valid.
- alu_op_i  input  4  ALU operation code: ADD=0, OR=1, SLL=2, SRL=3, SUB=4, AND=5, XOR=6, EQU=7.
- alu_src_i  input  1  1 selects the immediate as operand B.
- reg_write_i  input  1  the instruction writes rd.
- rs1_addr_i, rs2_addr_i, rd_addr_i  input  ADDR_WIDTH  register indices.
- rs1_data_i, rs2_data_i, imm_i  input  DATA_WIDTH  register-file read data and immediate.
- ex_mem_reg_write_i  input  1  EX/MEM stage will write back.
- ex_mem_rd_i  input  ADDR_WIDTH  EX/MEM destination register.
- ex_mem_result_i  input  DATA_WIDTH  EX/MEM result.
- mem_wb_reg_write_i  input  1  MEM/WB stage will write back.
- mem_wb_rd_i  input  ADDR_WIDTH  MEM/WB destination register.
- mem_wb_result_i  input  DATA_WIDTH  MEM/WB result.
- alu_operation_o  output  4  to ALU_Operation_i.
- alu_a_o, alu_b_o  output  DATA_WIDTH  to A_i and B_i.
- store_data_o  output  DATA_WIDTH  forwarded rs2 value, for stores.
- rd_addr_o  output  ADDR_WIDTH  registered rd.
- reg_write_o  output  1  registered reg_write, qualified by valid.
- valid_o  output  1  the stage holds a valid instruction.

Behaviour:
- Reset is asynchronous and active-high. Assertion clears all state immediately, independent of clk:
  - valid_o=0, reg_write_o=0, rd_addr_o=0, alu_operation_o=ADD(0).
  - Registered operands, immediate and addresses = 0.
  - Combinational outputs therefore read alu_a_o=0, alu_b_o=0, store_data_o=0, unless a forwarding condition matches on address 0, which is excluded below.
- Capture rule at each rising edge, with priority flush > stall > load:
  - flush_i=1: load a bubble. valid=0, reg_write=0, alu_op=ADD, all data and addresses=0.
  - stall_i=1 (no flush): all registers hold.
  - Otherwise: load all *_i fields. Stored reg_write = reg_write_i & valid_i. Stored valid = valid_i.
- Latency: a field presented at edge N appears on the registered outputs after edge N. Forwarded outputs follow same-cycle changes on the ex_mem_*/mem_wb_* inputs combinationally.
- Forwarding (combinational, from registered rs1/rs2 addresses), evaluated per source register:
  - If ex_mem_reg_write_i=1, ex_mem_rd_i≠0 and ex_mem_rd_i==rs, select ex_mem_result_i.
  - Else if mem_wb_reg_write_i=1, mem_wb_rd_i≠0 and mem_wb_rd_i==rs, select mem_wb_result_i.
  - Else select the registered register-file data.
  - Register x0 is never forwarded. When both stages match, EX/MEM wins.
- alu_a_o = forwarded rs1.
- store_data_o = forwarded rs2, regardless of alu_src.
- Operand B: b_pre = alu_src ? registered imm : forwarded rs2.
- Shift masking: when alu_operation_o is SLL or SRL, alu_b_o = {zeros, b_pre[SHAMT_WIDTH-1:0]}. Otherwise alu_b_o = b_pre.
- alu_operation_o outputs the registered code verbatim, including the undefined codes 8–15.
- Bubble: valid_o=0 forces reg_write_o=0. The operand outputs are don't-care to downstream but must be deterministic.
- Reset asserted mid-stall or mid-flush: reset dominates. After reset deasserts, normal capture resumes at the next edge.

Test Plan:
- Reset asserted asynchronously between edges → valid_o, reg_write_o, alu_operation_o, rd_addr_o all 0 before the next edge.
- Load ADD: rs1=3 (data 10), rs2=4 (data 20), no hazards → after one edge alu_a_o=10, alu_b_o=20, alu_operation_o=0.
- Double hazard: rs1=5, ex_mem rd=5 result 0xAA, mem_wb rd=5 result 0xBB, both writing → alu_a_o=0xAA. Drop ex_mem_reg_write_i → alu_a_o=0xBB. Set rd=0 with rs1=0 → alu_a_o = the registered data.
- SLL: forwarded rs2=0x0000_0123, alu_src=0 → alu_b_o=0x03. Same with alu_src=1, imm=0x25 → alu_b_o=0x05. store_data_o=0x123 in both cases.
- stall_i=1 for 3 cycles with changing inputs → registered outputs frozen. flush_i=1 and stall_i=1 together → bubble: valid_o=0, reg_write_o=0, alu_operation_o=0.
- valid_i=0, reg_write_i=1 → reg_write_o=0 after the edge.
